// File: rtl/dram_arbiter_if.sv
// ---------------------------------------------------------------------------
// dram_arbiter_if
// Bundles every signal between the dram arbiter, its two requesters and the
// sdram controller.
//
// Signals (directions given from the arbiter's side):
//   p0_req/p0_we/p0_addr/p0_wdata    in   port 0 (cpu) request and payload
//   p0_ack/p0_rdata/p0_err           out  port 0 completion, read data, timeout flag
//   p1_*                             -    the same set for port 1 (vga/gpu fetch)
//   m_addr/m_wdata/m_read/m_write    out  address, data and strobes to the controller
//   m_rdata/m_busy/m_ready           in   controller read data, busy, completion
//
// Modports:
//   slave  - the arbiter itself
//   master - the surroundings (requesters plus controller), e.g. a testbench
// ---------------------------------------------------------------------------
interface dram_arbiter_if #(
    parameter int AW = 24,
    parameter int DW = 16
) ();

    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_ack;
    logic [DW-1:0] p0_rdata;
    logic          p0_err;

    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_ack;
    logic [DW-1:0] p1_rdata;
    logic          p1_err;

    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_read;
    logic          m_write;
    logic [DW-1:0] m_rdata;
    logic          m_busy;
    logic          m_ready;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ack, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_rdata, p1_err,
        output m_addr, m_wdata, m_read, m_write,
        input  m_rdata, m_busy, m_ready
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ack, p0_rdata, p0_err,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_rdata, p1_err,
        input  m_addr, m_wdata, m_read, m_write,
        output m_rdata, m_busy, m_ready
    );

endinterface

// File: rtl/dram_arbiter.sv
// ---------------------------------------------------------------------------
// dram_arbiter
// Shares the single sdram controller port between port 0 (cpu data bus) and
// port 1 (vga/gpu framebuffer fetch). One transaction is outstanding at a
// time. Port 1 has priority, but after STARVE consecutive port-1 grants with
// port 0 waiting, port 0 is served. A watchdog completes a transaction with
// an error if the controller never answers.
//
// Ports:
//   i_clki   in   single clock, all logic on the rising edge
//   i_rst    in   synchronous, active-high reset
//   bus      -    dram_arbiter_if.slave: requester ports p0_*/p1_* and the
//                 controller port m_*
// ---------------------------------------------------------------------------
module dram_arbiter #(
    parameter int AW      = 24,
    parameter int DW      = 16,
    parameter int STARVE  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic           i_clki,
    input  logic           i_rst,
    dram_arbiter_if.slave  bus
);

    localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t        r_state;
    state_t        w_stateNext;

    logic          r_id;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [SW-1:0] r_starveCnt;
    logic [7:0]    r_toCnt;

    logic          r_p0Ack;
    logic          r_p1Ack;
    logic          r_p0Err;
    logic          r_p1Err;
    logic [DW-1:0] r_p0Rdata;
    logic [DW-1:0] r_p1Rdata;

    logic          w_starved;
    logic          w_grant0;
    logic          w_grant1;
    logic          w_toHit;
    logic          w_mRead;
    logic          w_mWrite;

    // Port 0 is starved once it has watched STARVE port-1 grants go by; only
    // then does port 1 lose its priority.
    assign w_starved = bus.p0_req && (r_starveCnt == SW'(STARVE));
    assign w_grant1  = bus.p1_req && !w_starved;
    assign w_grant0  = !w_grant1 && bus.p0_req;

    // The watchdog fires in the WAIT cycle whose increment would reach
    // TIMEOUT, so the error ack lands TIMEOUT+1 cycles after the strobe.
    assign w_toHit = ((r_toCnt + 8'd1) == 8'(TIMEOUT));

    // Next-state and strobe decode. The strobe is combinational in ISSUE so
    // it follows m_busy within the same cycle and lasts exactly one cycle.
    always_comb begin
        w_stateNext = r_state;
        w_mRead     = 1'b0;
        w_mWrite    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_grant0 || w_grant1) begin
                    w_stateNext = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!bus.m_busy) begin
                    w_mRead     = !r_we;
                    w_mWrite    = r_we;
                    w_stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.m_ready || w_toHit) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // State register plus the datapath: grant latch, starvation counter,
    // watchdog counter and the per-port completion registers. Acks and errors
    // are one-cycle pulses, so they default low every cycle.
    always_ff @(posedge i_clki) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_id        <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_starveCnt <= '0;
            r_toCnt     <= '0;
            r_p0Ack     <= 1'b0;
            r_p1Ack     <= 1'b0;
            r_p0Err     <= 1'b0;
            r_p1Err     <= 1'b0;
            r_p0Rdata   <= '0;
            r_p1Rdata   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_p0Ack <= 1'b0;
            r_p1Ack <= 1'b0;
            r_p0Err <= 1'b0;
            r_p1Err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_toCnt <= '0;
                    if (w_grant1) begin
                        r_id    <= 1'b1;
                        r_we    <= bus.p1_we;
                        r_addr  <= bus.p1_addr;
                        r_wdata <= bus.p1_wdata;
                    end else if (w_grant0) begin
                        r_id    <= 1'b0;
                        r_we    <= bus.p0_we;
                        r_addr  <= bus.p0_addr;
                        r_wdata <= bus.p0_wdata;
                    end
                    // Counts only port-1 wins that port 0 had to sit through.
                    if (w_grant0 || !bus.p0_req) begin
                        r_starveCnt <= '0;
                    end else if (w_grant1 && (r_starveCnt != SW'(STARVE))) begin
                        r_starveCnt <= r_starveCnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus.m_ready) begin
                        r_toCnt <= '0;
                        if (r_id) begin
                            r_p1Ack <= 1'b1;
                            if (!r_we) begin
                                r_p1Rdata <= bus.m_rdata;
                            end
                        end else begin
                            r_p0Ack <= 1'b1;
                            if (!r_we) begin
                                r_p0Rdata <= bus.m_rdata;
                            end
                        end
                    end else if (w_toHit) begin
                        r_toCnt <= '0;
                        if (r_id) begin
                            r_p1Ack <= 1'b1;
                            r_p1Err <= 1'b1;
                        end else begin
                            r_p0Ack <= 1'b1;
                            r_p0Err <= 1'b1;
                        end
                    end else begin
                        r_toCnt <= r_toCnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.p0_ack   = r_p0Ack;
    assign bus.p0_err   = r_p0Err;
    assign bus.p0_rdata = r_p0Rdata;
    assign bus.p1_ack   = r_p1Ack;
    assign bus.p1_err   = r_p1Err;
    assign bus.p1_rdata = r_p1Rdata;
    assign bus.m_addr   = r_addr;
    assign bus.m_wdata  = r_wdata;
    assign bus.m_read   = w_mRead;
    assign bus.m_write  = w_mWrite;

endmodule

// File: tb/tb_dram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dram_arbiter
// Scoreboard bench for dram_arbiter. The main thread plays both requesters,
// pushing the expected controller strobe and requester ack for every
// transaction. A controller model answers strobes, and a monitor pops and
// compares whenever the DUT strobes the controller or acks a requester.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dram_arbiter;

    localparam int AW      = 24;
    localparam int DW      = 16;
    localparam int STARVE  = 4;
    localparam int TIMEOUT = 255;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } strobe_t;

    typedef struct packed {
        logic          port;
        logic          err;
        logic [DW-1:0] rdata;
    } ack_t;

    logic clk = 1'b0;
    logic rst;

    strobe_t strobeQ[$];
    ack_t    ackQ[$];
    int      nChecks = 0;
    int      nErrors = 0;
    int      cycle = 0;

    int          cfgDelay;
    logic [DW-1:0] cfgRdata;
    logic        cfgNoReady;
    logic        modelReady;
    logic        forceReady;
    logic [DW-1:0] modelRdata;

    always #5 clk = ~clk;

    // Free-running cycle index used for latency checks.
    always @(posedge clk) cycle <= cycle + 1;

    dram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dram_arbiter #(
        .AW(AW), .DW(DW), .STARVE(STARVE), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clki (clk),
        .i_rst  (rst),
        .bus    (bus)
    );

    assign bus.m_ready = modelReady | forceReady;
    assign bus.m_rdata = modelRdata;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expectTxn(input logic port, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic err, input logic [DW-1:0] rdata);
        strobe_t s;
        ack_t    a;
        s.we = we; s.addr = addr; s.wdata = wdata;
        a.port = port; a.err = err; a.rdata = rdata;
        strobeQ.push_back(s);
        ackQ.push_back(a);
    endtask

    task automatic applyStimulus(input logic port, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata);
        if (port) begin
            bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_req = 1'b1;
        end else begin
            bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_req = 1'b1;
        end
    endtask

    // Waits for the port's ack and drops its request in the ack cycle itself,
    // before the arbiter re-samples it.
    task automatic waitAck(input logic port, input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (port ? bus.p1_ack : bus.p0_ack) got = 1'b1;
        end
        if (port) bus.p1_req = 1'b0;
        else      bus.p0_req = 1'b0;
        checkOutput(port ? "ackWithinBudget1" : "ackWithinBudget0", got, 1'b1);
    endtask

    task automatic checkIdleOutputs(input string tag, input logic [DW-1:0] rd0, input logic [DW-1:0] rd1);
        checkOutput({tag, ".p0Ack"},   bus.p0_ack,   0);
        checkOutput({tag, ".p1Ack"},   bus.p1_ack,   0);
        checkOutput({tag, ".p0Err"},   bus.p0_err,   0);
        checkOutput({tag, ".p1Err"},   bus.p1_err,   0);
        checkOutput({tag, ".mRead"},   bus.m_read,   0);
        checkOutput({tag, ".mWrite"},  bus.m_write,  0);
        checkOutput({tag, ".p0Rdata"}, bus.p0_rdata, rd0);
        checkOutput({tag, ".p1Rdata"}, bus.p1_rdata, rd1);
    endtask

    // Controller model: answers each strobe with a one-cycle m_ready
    // cfgDelay cycles after the strobe cycle, unless told to stay silent.
    initial begin
        modelReady = 1'b0;
        modelRdata = '0;
        forever begin
            @(negedge clk);
            if (!rst && (bus.m_read || bus.m_write) && !cfgNoReady) begin
                repeat (cfgDelay) @(posedge clk);
                #1;
                modelReady = 1'b1;
                modelRdata = cfgRdata;
                @(posedge clk);
                #1;
                modelReady = 1'b0;
            end
        end
    end

    // Monitor: compares every strobe and every ack against the scoreboard,
    // and checks strobe exclusivity and completion latency.
    initial begin
        strobe_t s;
        ack_t    a;
        int      outstanding;
        int      lastStrobeCycle;
        int      lastReadyCycle;
        outstanding = 0;
        lastStrobeCycle = 0;
        lastReadyCycle = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                outstanding = 0;
            end else begin
                if (bus.m_read || bus.m_write) begin
                    checkOutput("strobeExclusive", bus.m_read & bus.m_write, 0);
                    checkOutput("strobeOverlap", outstanding, 0);
                    checkOutput("strobeWhileBusy", bus.m_busy, 0);
                    checkOutput("strobeExpected", strobeQ.size() != 0, 1);
                    if (strobeQ.size() != 0) begin
                        s = strobeQ.pop_front();
                        checkOutput("strobeWe",    bus.m_write, s.we);
                        checkOutput("strobeAddr",  bus.m_addr,  s.addr);
                        checkOutput("strobeWdata", bus.m_wdata, s.wdata);
                    end
                    lastStrobeCycle = cycle;
                    outstanding = 1;
                end
                if (bus.m_ready && outstanding != 0) begin
                    lastReadyCycle = cycle;
                    outstanding = 0;
                end
                if (bus.p0_ack || bus.p1_ack) begin
                    checkOutput("ackExclusive", bus.p0_ack & bus.p1_ack, 0);
                    checkOutput("ackExpected", ackQ.size() != 0, 1);
                    if (ackQ.size() != 0) begin
                        a = ackQ.pop_front();
                        checkOutput("ackPort",  bus.p1_ack, a.port);
                        checkOutput("ackErr",   a.port ? bus.p1_err : bus.p0_err, a.err);
                        checkOutput("ackRdata", a.port ? bus.p1_rdata : bus.p0_rdata, a.rdata);
                        if (a.err) begin
                            checkOutput("timeoutLatency", cycle - lastStrobeCycle, 256);
                            outstanding = 0;
                        end else begin
                            checkOutput("ackLatency", cycle - lastReadyCycle, 1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int n0;
        int n1;
        int acks;
        logic done;

        rst = 1'b1;
        bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
        bus.m_busy = 1'b0;
        cfgDelay = 1; cfgRdata = '0; cfgNoReady = 1'b0; forceReady = 1'b0;

        repeat (3) @(negedge clk);
        checkIdleOutputs("reset", 16'h0000, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single p0 write, ready 3 cycles after strobe");
        cfgDelay = 3;
        expectTxn(0, 1, 24'h000012, 16'hBEEF, 0, 16'h0000);
        applyStimulus(0, 1, 24'h000012, 16'hBEEF);
        waitAck(0, 50);

        $display("[TB] p0 read returning 0x1234");
        cfgDelay = 1; cfgRdata = 16'h1234;
        expectTxn(0, 0, 24'h000034, 16'h0000, 0, 16'h1234);
        applyStimulus(0, 0, 24'h000034, 16'h0000);
        waitAck(0, 50);
        repeat (2) @(negedge clk);

        $display("[TB] both ports requesting continuously");
        n0 = 0; n1 = 0;
        for (int i = 0; i < 10; i++) begin
            if (order[i] == 1) begin
                expectTxn(1, 1, 24'h000200, 16'(32'hB000 + n1), 0, 16'h0000);
                n1++;
            end else begin
                expectTxn(0, 1, 24'h000100, 16'(32'hA000 + n0), 0, 16'h1234);
                n0++;
            end
        end
        applyStimulus(0, 1, 24'h000100, 16'hA000);
        applyStimulus(1, 1, 24'h000200, 16'hB000);
        acks = 0;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (bus.p0_ack) begin acks++; bus.p0_wdata = bus.p0_wdata + 16'd1; end
            if (bus.p1_ack) begin acks++; bus.p1_wdata = bus.p1_wdata + 16'd1; end
            if (acks >= 10) done = 1'b1;
        end
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        checkOutput("grantLoopAcks", acks, 10);
        repeat (3) @(negedge clk);

        $display("[TB] p1 read with m_busy held for 10 cycles");
        cfgRdata = 16'h5A5A;
        bus.m_busy = 1'b1;
        expectTxn(1, 0, 24'h000345, 16'h0000, 0, 16'h5A5A);
        applyStimulus(1, 0, 24'h000345, 16'h0000);
        repeat (10) @(negedge clk);
        checkOutput("busyNoStrobe", strobeQ.size(), 1);
        @(posedge clk);
        #1 bus.m_busy = 1'b0;
        waitAck(1, 50);

        $display("[TB] controller silent, watchdog completion");
        cfgNoReady = 1'b1;
        expectTxn(0, 0, 24'h000300, 16'h0000, 1, 16'h1234);
        applyStimulus(0, 0, 24'h000300, 16'h0000);
        waitAck(0, 400);
        cfgNoReady = 1'b0; cfgRdata = 16'h0F0F;
        expectTxn(0, 0, 24'h000301, 16'h0000, 0, 16'h0F0F);
        applyStimulus(0, 0, 24'h000301, 16'h0000);
        waitAck(0, 50);

        $display("[TB] reset during WAIT, then stray m_ready");
        cfgNoReady = 1'b1;
        strobeQ.push_back(strobe_t'{1'b1, 24'h000400, 16'hCAFE});
        applyStimulus(1, 1, 24'h000400, 16'hCAFE);
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (strobeQ.size() == 0) done = 1'b1;
        end
        checkOutput("rstStrobeSeen", strobeQ.size(), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus.p1_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 forceReady = 1'b1;
        @(posedge clk);
        #1 forceReady = 1'b0;
        repeat (5) @(negedge clk);
        checkIdleOutputs("afterRst", 16'h0000, 16'h0000);
        cfgNoReady = 1'b0; cfgRdata = 16'h7777;
        expectTxn(0, 0, 24'h000500, 16'h0000, 0, 16'h7777);
        applyStimulus(0, 0, 24'h000500, 16'h0000);
        waitAck(0, 50);

        repeat (5) @(negedge clk);
        checkOutput("scoreboardEmpty", strobeQ.size() + ackQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
